// File: rtl/nibble_deserializer_pkg.sv
// Shared definitions for the framed serial nibble deserializer.
package nibble_deserializer_pkg;

  localparam int   DEF_WIDTH = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/nibble_parity_chk.sv
// Even-parity check over data plus parity bit; odd_n=1 means the frame is good.
module nibble_parity_chk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par,
  output logic             odd_n
);

  assign odd_n = ~(^data ^ par);

endmodule

// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel front end for the 4-bit load/clear register.
// Frame results are staged one cycle in pend_* so load lands on the edge
// after the stop-bit sample, overlapping a back-to-back frame's DATA state.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] d,
  output logic             load,
  output logic             clear,
  output logic             busy,
  output logic             par_err,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bit;
  logic             odd_n;
  logic             par_ok;
  logic             pend_load;
  logic             pend_perr;
  logic             pend_ferr;

  nibble_parity_chk #(.WIDTH(WIDTH)) u_par (
    .data  (shreg),
    .par   (par_bit),
    .odd_n (odd_n)
  );

  // Without a parity bit every frame counts as parity-clean.
  assign par_ok = PARITY_EN ? odd_n : 1'b1;
  assign busy   = (state != IDLE);

  // Frame FSM: consumes one bit per strobe; flush aborts and empties.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      pend_load <= 1'b0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      pend_load <= 1'b0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
    end else begin
      pend_load <= 1'b0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (serial_in == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            for (int i = 0; i < WIDTH; i++)
              if (cnt == CW'(i)) shreg[i] <= serial_in;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            par_bit <= serial_in;
            state   <= STOP;
          end
          STOP: begin
            state     <= IDLE;
            pend_load <= (serial_in == STOP_BIT) && par_ok;
            pend_perr <= !par_ok;
            pend_ferr <= (serial_in != STOP_BIT);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output stage: one-cycle pulses; flush wins and cancels any pending load.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      d         <= '0;
      load      <= 1'b0;
      clear     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else if (flush) begin
      d         <= '0;
      load      <= 1'b0;
      clear     <= 1'b1;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clear     <= 1'b0;
      load      <= pend_load;
      par_err   <= pend_perr;
      frame_err <= pend_ferr;
      if (pend_load) d <= shreg;
    end
  end

endmodule
